hms_updown_timer: RTL and testbench

Parametrised hours:minutes:seconds timekeeper with a built-in clock prescaler, loadable BCD value, and selectable up-count (clock/stopwatch) or down-count (timer) mode. It replaces the separate usec/msec/sec/min/hour dividers and the 60-count cascade with one block. The block emits one-cycle roll-over pulses and a timer-done flag. It sits between the system clock and the display/FND driver and control FSMs.

---
 rtl/hms_updown_timer_pkg.sv | 35 +++
 rtl/hms_updown_timer_bcd_mod_pair.sv | 69 ++++++
 rtl/hms_updown_timer.sv | 107 ++++++++++
 tb/tb_hms_updown_timer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hms_updown_timer_pkg.sv
// Shared time definitions for the hms timer: BCD digit widths, tens limits,
// field offsets on the packed hms bus and a load-legality helper.
package hms_updown_timer_pkg;

  localparam int DIGIT_W   = 4;
  localparam int PAIR_W    = 2 * DIGIT_W;
  localparam int SEC10_MAX = 5;
  localparam int MIN10_MAX = 5;

  localparam int S1_LSB  = 0;
  localparam int S10_LSB = 4;
  localparam int M1_LSB  = 8;
  localparam int M10_LSB = 12;
  localparam int H1_LSB  = 16;
  localparam int H10_LSB = 20;
  localparam int SEC_LSB  = S1_LSB;
  localparam int MIN_LSB  = M1_LSB;
  localparam int HOUR_LSB = H1_LSB;

  // Legal when every digit is decimal, tens of s/m fit 0..5, hours < hour_mod.
  function automatic logic bcd_legal(input logic [23:0] v, input int hour_mod);
    logic ok;
    int   hours;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] > 4'd9) ok = 1'b0;
    end
    if (int'(v[S10_LSB +: DIGIT_W]) > SEC10_MAX) ok = 1'b0;
    if (int'(v[M10_LSB +: DIGIT_W]) > MIN10_MAX) ok = 1'b0;
    hours = int'(v[H10_LSB +: DIGIT_W]) * 10 + int'(v[H1_LSB +: DIGIT_W]);
    if (hours >= hour_mod) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/hms_updown_timer_bcd_mod_pair.sv
// Two-digit BCD modulo counter (tens/ones) counting up or down, with a
// combinational wrap flag that doubles as the carry/borrow to the next pair.
module hms_updown_timer_bcd_mod_pair
  import hms_updown_timer_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dir,
  input  logic              ld,
  input  logic [PAIR_W-1:0] ld_val,
  output logic [PAIR_W-1:0] pair,
  output logic              wrap,
  output logic              is_zero
);

  localparam logic [DIGIT_W-1:0] TOP_T = DIGIT_W'((MOD - 1) / 10);
  localparam logic [DIGIT_W-1:0] TOP_O = DIGIT_W'((MOD - 1) % 10);

  logic [DIGIT_W-1:0] tens, ones, tens_nxt, ones_nxt;
  logic               at_top;

  assign pair    = {tens, ones};
  assign at_top  = (tens == TOP_T) && (ones == TOP_O);
  assign is_zero = (tens == '0) && (ones == '0);
  assign wrap    = en && (dir ? is_zero : at_top);

  always_comb begin
    tens_nxt = tens;
    ones_nxt = ones;
    if (ld) begin
      tens_nxt = ld_val[PAIR_W-1 -: DIGIT_W];
      ones_nxt = ld_val[DIGIT_W-1:0];
    end else if (en && !dir) begin
      if (at_top) begin
        tens_nxt = '0;
        ones_nxt = '0;
      end else if (ones == 4'd9) begin
        tens_nxt = tens + 4'd1;
        ones_nxt = '0;
      end else begin
        ones_nxt = ones + 4'd1;
      end
    end else if (en && dir) begin
      if (is_zero) begin
        tens_nxt = TOP_T;
        ones_nxt = TOP_O;
      end else if (ones == '0) begin
        tens_nxt = tens - 4'd1;
        ones_nxt = 4'd9;
      end else begin
        ones_nxt = ones - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens <= '0;
      ones <= '0;
    end else begin
      tens <= tens_nxt;
      ones <= ones_nxt;
    end
  end

endmodule

// File: rtl/hms_updown_timer.sv
// Hours:minutes:seconds up/down timekeeper with inline usec/sec prescaler,
// validated BCD load, registered roll-over pulses and a down-count done flag.
module hms_updown_timer
  import hms_updown_timer_pkg::*;
#(
  parameter int CLK_PER_USEC = 100,
  parameter int USEC_PER_SEC = 1000000,
  parameter int HOUR_MOD     = 24
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        run,
  input  logic        mode,
  input  logic        load,
  input  logic [23:0] set_hms,
  output logic [23:0] hms,
  output logic        tick_sec,
  output logic        min_pulse,
  output logic        hour_pulse,
  output logic        day_pulse,
  output logic        done,
  output logic        load_err
);

  localparam int UW = $clog2(CLK_PER_USEC);
  localparam int SW = (USEC_PER_SEC > 1) ? $clog2(USEC_PER_SEC) : 1;
  localparam logic [UW-1:0] USEC_LAST = UW'(CLK_PER_USEC - 1);
  localparam logic [SW-1:0] SEC_LAST  = SW'(USEC_PER_SEC - 1);
  localparam int SEC_MOD = (SEC10_MAX + 1) * 10;
  localparam int MIN_MOD = (MIN10_MAX + 1) * 10;

  logic [UW-1:0]     usec_cnt;
  logic [SW-1:0]     sec_cnt;
  logic              legal, load_ok, tick, advance, hold_zero;
  logic              all_zero, one_left;
  logic [PAIR_W-1:0] sec_pair, min_pair, hour_pair;
  logic              sec_wrap, min_wrap, hour_wrap;
  logic              sec_zero, min_zero, hour_zero;

  assign legal     = bcd_legal(set_hms, HOUR_MOD);
  assign load_ok   = load && legal;
  // A load of either kind swallows a coinciding prescaler tick.
  assign tick      = run && !load && (usec_cnt == USEC_LAST) && (sec_cnt == SEC_LAST);
  assign all_zero  = sec_zero && min_zero && hour_zero;
  assign one_left  = min_zero && hour_zero && (sec_pair == 8'h01);
  // Expired down count stays parked at zero; no borrow into 23:59:59.
  assign hold_zero = mode && (all_zero || done);
  assign advance   = tick && !hold_zero;
  assign hms       = {hour_pair, min_pair, sec_pair};

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      usec_cnt <= '0;
      sec_cnt  <= '0;
    end else if (load_ok) begin
      usec_cnt <= '0;
      sec_cnt  <= '0;
    end else if (run && !load) begin
      if (usec_cnt == USEC_LAST) begin
        usec_cnt <= '0;
        sec_cnt  <= (sec_cnt == SEC_LAST) ? '0 : sec_cnt + SW'(1);
      end else begin
        usec_cnt <= usec_cnt + UW'(1);
      end
    end
  end

  hms_updown_timer_bcd_mod_pair #(.MOD(SEC_MOD)) u_sec (
    .clk(clk), .rst(reset_p), .en(advance), .dir(mode), .ld(load_ok),
    .ld_val(set_hms[SEC_LSB +: PAIR_W]), .pair(sec_pair), .wrap(sec_wrap),
    .is_zero(sec_zero)
  );

  hms_updown_timer_bcd_mod_pair #(.MOD(MIN_MOD)) u_min (
    .clk(clk), .rst(reset_p), .en(sec_wrap), .dir(mode), .ld(load_ok),
    .ld_val(set_hms[MIN_LSB +: PAIR_W]), .pair(min_pair), .wrap(min_wrap),
    .is_zero(min_zero)
  );

  hms_updown_timer_bcd_mod_pair #(.MOD(HOUR_MOD)) u_hour (
    .clk(clk), .rst(reset_p), .en(min_wrap), .dir(mode), .ld(load_ok),
    .ld_val(set_hms[HOUR_LSB +: PAIR_W]), .pair(hour_pair), .wrap(hour_wrap),
    .is_zero(hour_zero)
  );

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      tick_sec   <= 1'b0;
      min_pulse  <= 1'b0;
      hour_pulse <= 1'b0;
      day_pulse  <= 1'b0;
      load_err   <= 1'b0;
      done       <= 1'b0;
    end else begin
      tick_sec   <= tick;
      min_pulse  <= sec_wrap;
      hour_pulse <= min_wrap;
      day_pulse  <= hour_wrap && !mode;
      load_err   <= load && !legal;
      if (load_ok || !mode)
        done <= 1'b0;
      else if (tick && (all_zero || one_left))
        done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hms_updown_timer.sv
// Self-checking bench for hms_updown_timer: directed scenarios plus random
// run/mode/load traffic, all checked against a seconds-count reference model.
module tb_hms_updown_timer;

  localparam int CPU   = 2;
  localparam int UPS   = 3;
  localparam int HMOD  = 24;
  localparam int PER   = CPU * UPS;
  localparam int DAY   = HMOD * 3600;

  logic        clk = 1'b0;
  logic        reset_p, run, mode, load;
  logic [23:0] set_hms, hms;
  logic        tick_sec, min_pulse, hour_pulse, day_pulse, done, load_err;

  int tests  = 0;
  int failed = 0;

  // reference model state
  int   m_secs, m_phase;
  logic m_done, m_tick, m_min, m_hour, m_day, m_err;

  hms_updown_timer #(.CLK_PER_USEC(CPU), .USEC_PER_SEC(UPS), .HOUR_MOD(HMOD)) dut (
    .clk(clk), .reset_p(reset_p), .run(run), .mode(mode), .load(load),
    .set_hms(set_hms), .hms(hms), .tick_sec(tick_sec), .min_pulse(min_pulse),
    .hour_pulse(hour_pulse), .day_pulse(day_pulse), .done(done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int t);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int dig(input logic [23:0] v, input int i);
    return int'((v >> (4 * i)) & 24'hF);
  endfunction

  function automatic logic is_legal(input logic [23:0] v);
    for (int i = 0; i < 6; i++) if (dig(v, i) > 9) return 1'b0;
    if (dig(v, 1) > 5 || dig(v, 3) > 5) return 1'b0;
    return (dig(v, 5) * 10 + dig(v, 4)) < HMOD;
  endfunction

  function automatic int to_secs(input logic [23:0] v);
    return (dig(v, 5) * 10 + dig(v, 4)) * 3600 + (dig(v, 3) * 10 + dig(v, 2)) * 60
           + dig(v, 1) * 10 + dig(v, 0);
  endfunction

  task automatic model_reset();
    m_secs = 0; m_phase = 0; m_done = 1'b0;
    {m_tick, m_min, m_hour, m_day, m_err} = '0;
  endtask

  task automatic model_edge(input logic r, input logic md, input logic ld, input logic [23:0] v);
    {m_tick, m_min, m_hour, m_day, m_err} = '0;
    if (ld) begin
      if (is_legal(v)) begin
        m_secs = to_secs(v); m_phase = 0; m_done = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else if (r) begin
      if (m_phase == PER - 1) begin
        m_phase = 0;
        m_tick  = 1'b1;
        if (!md) begin
          m_min  = (m_secs % 60) == 59;
          m_hour = (m_secs % 3600) == 3599;
          m_day  = m_secs == DAY - 1;
          m_secs = (m_secs + 1) % DAY;
        end else if (m_secs == 0 || m_done) begin
          m_done = 1'b1;
        end else begin
          m_min  = (m_secs % 60) == 0;
          m_hour = (m_secs % 3600) == 0;
          m_secs = m_secs - 1;
          if (m_secs == 0) m_done = 1'b1;
        end
      end else begin
        m_phase++;
      end
    end
    if (!md) m_done = 1'b0;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic md, input logic ld, input logic [23:0] v);
    run = r; mode = md; load = ld; set_hms = v;
    @(posedge clk);
    model_edge(r, md, ld, v);
    #1;
    check("hms", hms, to_bcd(m_secs));
    check("flags", {18'd0, tick_sec, min_pulse, hour_pulse, day_pulse, done, load_err},
          {18'd0, m_tick, m_min, m_hour, m_day, m_done, m_err});
  endtask

  function automatic logic [23:0] rand_hms();
    if ($urandom_range(3) == 0)
      return {20'h00000, 4'($urandom_range(3))};
    return {4'($urandom_range(2)), 4'($urandom_range(9)), 4'($urandom_range(6)),
            4'($urandom_range(9)), 4'($urandom_range(6)), 4'($urandom_range(9))};
  endfunction

  initial begin
    logic md;
    reset_p = 1'b1; run = 1'b0; mode = 1'b0; load = 1'b0; set_hms = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_hms", hms, 24'h000000);
    check("reset_flags", {18'd0, tick_sec, min_pulse, hour_pulse, day_pulse, done, load_err}, 24'd0);
    @(negedge clk);
    reset_p = 1'b0;

    // up wrap 23:59:58 -> 23:59:59 -> 00:00:00
    step(1, 0, 1, 24'h235958);
    repeat (PER) step(1, 0, 0, 24'h0);
    check("up_first_tick", hms, 24'h235959);
    repeat (PER) step(1, 0, 0, 24'h0);
    check("up_wrap_hms", hms, 24'h000000);
    check("up_wrap_pulses", {21'd0, min_pulse, hour_pulse, day_pulse}, 24'd7);

    // down expiry and hold at zero
    step(1, 1, 1, 24'h000002);
    repeat (PER * 4) step(1, 1, 0, 24'h0);
    check("down_done", {23'd0, done}, 24'd1);
    check("down_hold", hms, 24'h000000);

    // borrow across minutes and hours
    step(1, 1, 1, 24'h010000);
    repeat (PER) step(1, 1, 0, 24'h0);
    check("borrow_hms", hms, 24'h005959);
    check("borrow_pulses", {22'd0, min_pulse, hour_pulse}, 24'd3);

    // pause stretches the tick period
    step(1, 0, 1, 24'h000000);
    repeat (4) step(1, 0, 0, 24'h0);
    repeat (10) step(0, 0, 0, 24'h0);
    step(1, 0, 0, 24'h0);
    check("pause_no_tick", {23'd0, tick_sec}, 24'd0);
    step(1, 0, 0, 24'h0);
    check("pause_tick", {23'd0, tick_sec}, 24'd1);

    // illegal load rejected
    step(1, 0, 0, 24'h0);
    step(1, 0, 1, 24'h006000);
    check("illegal_err", {23'd0, load_err}, 24'd1);
    check("illegal_hms", hms, 24'h000001);
    repeat (PER) step(1, 0, 0, 24'h0);

    // legal load coinciding with a tick
    step(1, 0, 1, 24'h000000);
    repeat (PER - 1) step(1, 0, 0, 24'h0);
    step(1, 0, 1, 24'h123456);
    check("load_tick_hms", hms, 24'h123456);
    check("load_tick_no_tick", {23'd0, tick_sec}, 24'd0);

    // asynchronous reset mid-count, from an expired down count
    step(1, 1, 1, 24'h000001);
    repeat (PER + 2) step(1, 1, 0, 24'h0);
    #2 reset_p = 1'b1;
    #1;
    model_reset();
    check("async_rst_hms", hms, 24'h000000);
    check("async_rst_done", {23'd0, done}, 24'd0);
    @(negedge clk);
    reset_p = 1'b0;
    repeat (PER + 1) step(1, 0, 0, 24'h0);

    // random traffic
    md = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(49) == 0) md = ~md;
      step($urandom_range(9) != 0, md, $urandom_range(29) == 0, rand_hms());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
